// File: rtl/mips_mem_pkg.sv
// Shared types and address checking for the data-memory responder.
// Error rule: the address is misaligned or its word index lies past the array.
package mips_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic addr_err(input logic [63:0] byte_addr, input int depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = (byte_addr % 64'(WORD_BYTES)) != 64'd0;
    out_of_range = (byte_addr / 64'(WORD_BYTES)) >= 64'(depth_words);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH_WORDS x 32 storage with a byte-lane synchronous write and an enabled synchronous read.
// The read register holds its value until the next enabled read.
module data_mem_array #(
  parameter  int DEPTH_WORDS = 64,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_be,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: accept in IDLE, WAIT_CYCLES wait states, one-cycle RESP.
// Response is sampled WAIT_CYCLES+1 edges after acceptance; req_ready is low outside IDLE.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_we;
  logic             r_err;
  logic             r_zero;

  logic             w_idle;
  logic             w_req_err;
  logic [IDX_W-1:0] w_req_idx;
  logic             w_enter_resp;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_zero;
  logic             w_arr_we;
  logic [31:0]      w_arr_rdata;

  assign w_idle    = (r_state == IDLE);
  assign w_req_err = addr_err(64'(req_addr), DEPTH_WORDS);
  assign w_req_idx = req_addr[IDX_W+1:2];

  // With zero wait states RESP is entered on the acceptance edge, so the read uses the live request.
  assign w_enter_resp = !reset &&
                        ((w_idle && req_valid && (WAIT_CYCLES == 0)) ||
                         ((r_state == WAIT) && (r_cnt == CNT_LAST)));
  assign w_rd_idx  = w_idle ? w_req_idx : r_idx;
  assign w_rd_zero = w_idle ? (req_we | w_req_err) : (r_we | r_err);
  assign w_arr_we  = !reset && w_idle && req_valid && req_we && !w_req_err;

  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_waddr (w_req_idx),
    .i_wdata (req_wdata),
    .i_be    (req_be),
    .i_re    (w_enter_resp),
    .i_raddr (w_rd_idx),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      if (w_enter_resp) r_zero <= w_rd_zero;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_idx <= w_req_idx;
            r_we  <= req_we;
            r_err <= w_req_err;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= RESP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = w_idle;
  assign rsp_valid = (r_state == RESP);
  // Stores and errors read back as zero; the mask and the array register change only on RESP entry.
  assign rsp_rdata = r_zero ? 32'd0 : w_arr_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=1 instance for function, plus
// WAIT_CYCLES=0 and WAIT_CYCLES=3 instances for latency and acceptance spacing.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v0, rdy0, rv0, e0;
  logic [31:0] d0;
  logic        v3, rdy3, rv3, e3;
  logic [31:0] d3;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1), .ADDR_W(32)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .ADDR_W(32)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_we(1'b0), .req_addr(32'd0),
    .req_wdata(32'd0), .req_be(4'd0), .req_ready(rdy0), .rsp_valid(rv0),
    .rsp_rdata(d0), .rsp_err(e0)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .ADDR_W(32)) u_w3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_we(1'b0), .req_addr(32'd0),
    .req_wdata(32'd0), .req_be(4'd0), .req_ready(rdy3), .rsp_valid(rv3),
    .rsp_rdata(d3), .rsp_err(e3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request on the main instance; records latency (in edges after acceptance), data and error.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    got_lat = 1;
    while (!rsp_valid && got_lat < 20) begin
      @(negedge clk);
      got_lat++;
    end
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    v0 = 1'b0; v3 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err",   {31'd0, rsp_err}, 32'd0);

    xact(1'b1, 32'd4, 32'd5, 4'hF);
    chk("st4_lat",   got_lat, 32'd2);
    chk("st4_err",   {31'd0, got_err}, 32'd0);
    chk("st4_rdata", got_rdata, 32'd0);

    xact(1'b0, 32'd4, 32'd0, 4'h0);
    chk("ld4_lat",   got_lat, 32'd2);
    chk("ld4_rdata", got_rdata, 32'd5);
    chk("ld4_err",   {31'd0, got_err}, 32'd0);

    xact(1'b1, 32'd12, 32'h0000_1234, 4'hF);
    xact(1'b1, 32'd13, 32'd10, 4'hF);
    chk("st13_err",   {31'd0, got_err}, 32'd1);
    chk("st13_rdata", got_rdata, 32'd0);
    xact(1'b0, 32'd12, 32'd0, 4'h0);
    chk("ld12_rdata", got_rdata, 32'h0000_1234);

    xact(1'b1, 32'd8, 32'hAABB_CCDD, 4'hF);
    xact(1'b1, 32'd8, 32'h0000_1100, 4'b0010);
    xact(1'b0, 32'd8, 32'd0, 4'h0);
    chk("ld8_merge", got_rdata, 32'hAABB_11DD);

    xact(1'b1, 32'd8, 32'hFFFF_FFFF, 4'h0);
    chk("be0_err", {31'd0, got_err}, 32'd0);
    xact(1'b0, 32'd8, 32'd0, 4'h0);
    chk("be0_unchanged", got_rdata, 32'hAABB_11DD);

    xact(1'b0, 32'd256, 32'd0, 4'h0);
    chk("ld256_err",   {31'd0, got_err}, 32'd1);
    chk("ld256_rdata", got_rdata, 32'd0);

    // Reset while the store to 20 is in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd20; req_wdata = 32'h77; req_be = 4'hF;
    @(negedge clk);
    chk("abort_in_wait", {31'd0, req_ready}, 32'd0);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    xact(1'b0, 32'd20, 32'd0, 4'h0);
    chk("ld20_committed", got_rdata, 32'h77);

    // A request presented during reset must not be accepted.
    xact(1'b1, 32'd24, 32'h11, 4'hF);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd24; req_wdata = 32'h99; req_be = 4'hF;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    chk("rst_req_ignored", {31'd0, req_ready}, 32'd1);
    xact(1'b0, 32'd24, 32'd0, 4'h0);
    chk("ld24_rdata", got_rdata, 32'h11);

    // Continuous requests on all three builds from a common reset.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd256; v0 = 1'b1; v3 = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("w1_ready_k%0d", k), {31'd0, req_ready}, {31'd0, (k % 3 == 0)});
      chk($sformatf("w1_valid_k%0d", k), {31'd0, rsp_valid}, {31'd0, (k % 3 == 2)});
      if (k % 3 == 2) begin
        chk($sformatf("w1_err_k%0d", k),   {31'd0, rsp_err}, 32'd1);
        chk($sformatf("w1_rdata_k%0d", k), rsp_rdata, 32'd0);
      end
      chk($sformatf("w0_ready_k%0d", k), {31'd0, rdy0}, {31'd0, (k % 2 == 0)});
      chk($sformatf("w0_valid_k%0d", k), {31'd0, rv0},  {31'd0, (k % 2 == 1)});
      chk($sformatf("w3_ready_k%0d", k), {31'd0, rdy3}, {31'd0, (k % 5 == 0)});
      chk($sformatf("w3_valid_k%0d", k), {31'd0, rv3},  {31'd0, (k % 5 == 4)});
      @(negedge clk);
    end
    req_valid = 1'b0; v0 = 1'b0; v3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
